issue_ctrl: RTL and testbench
=============================

Name: issue_ctrl

Overview:
- Issue controller between instDecoder and the execute stage.
- Holds one decoded instruction and tracks in-flight destination registers in a 32-entry scoreboard.
- Stalls on RAW/WAW hazards and on an unresolved branch; issues to execute through a valid/ready handshake.
- Honours pipeline flush and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- cRegNum, 32, number of architectural registers (scoreboard width).
- cAddrW, 5, register address width (log2 cRegNum).
- cStallCntW, 16, width of the stall-cycle counter.

Ports:
- iClk  in  1  clock; all logic on rising edge.
- iRst  in  1  synchronous, active-low reset.
- iDecValid  in  1  decoder presents an instruction.
- oDecReady  out  1  controller accepts the instruction this cycle.
- iRs1Addr / iRs2Addr / iRdAddr  in  cAddrW each  register fields from decoder.
- iUsesRs1 / iUsesRs2 / iWritesRd  in  1 each  operand-use and destination-write flags.
- iIsBranch  in  1  instruction is branch/jump.
- iFlushPipe  in  1  discard held instruction.
- iBrResolved  in  1  execute has resolved the outstanding branch.
- iWbValid  in  1  writeback retiring a register write.
- iWbAddr  in  cAddrW  writeback destination.
- iExReady  in  1  execute can accept.
- oIssueValid  out  1  held instruction is hazard-free and may issue.
- oIssueRs1Addr / oIssueRs2Addr / oIssueRdAddr  out  cAddrW  fields of the held instruction.
- oScoreboard  out  cRegNum  pending-write bitmap.
- oBrPending  out  1  a branch is in flight.
- oStallCnt  out  cStallCntW  saturating count of stall cycles.

Behaviour:
- Reset (iRst=0 at a clock edge):
  - State = EMPTY.
  - Scoreboard = 0, oStallCnt = 0, oBrPending = 0.
  - Held fields = 0, oIssueValid = 0.
  - oDecReady = 0 while iRst=0; it is 1 from the first cycle after release.
  - Reset mid-operation discards the held instruction and all scoreboard bits.
- States:
  - EMPTY: nothing held.
  - HELD: one instruction held.
  - BR_WAIT: a branch has issued; awaiting iBrResolved.
- Handshakes:
  - Accept = iDecValid && oDecReady.
  - Issue = oIssueValid && iExReady.
  - oIssueValid never depends on iExReady.
- oDecReady = (state==EMPTY) || (state==HELD && issue && !iIsBranch-of-held). It is 0 in BR_WAIT. An instruction accepted at edge N can issue at earliest in cycle N+1.
- Throughput: one instruction per cycle when hazard-free (issue and accept in the same cycle; HELD→HELD).
- Hazard on the held instruction:
  - Hazard = (usesRs1 && rs1!=0 && sb[rs1]) || (usesRs2 && rs2!=0 && sb[rs2]) || (writesRd && rd!=0 && sb[rd]).
  - The hazard uses the current registered scoreboard. A same-cycle writeback clear takes effect next cycle; there is no bypass.
- oIssueValid = (state==HELD) && !hazard.
- On issue:
  - If writesRd && rd!=0, set sb[rd] at the next edge.
  - If the held instruction is a branch, go to BR_WAIT, set oBrPending = 1, and deassert oDecReady.
  - Otherwise go to HELD if accepting, else EMPTY.
- Writeback: iWbValid clears sb[iWbAddr] at the next edge.
  - iWbAddr==0 is ignored.
  - Set and clear of the same bit in one cycle: set wins.
- BR_WAIT:
  - iBrResolved → EMPTY, oBrPending = 0.
  - iBrResolved together with iFlushPipe: same transition; no instruction is held, so nothing else to discard.
- Flush: iFlushPipe in HELD → EMPTY next edge. The held instruction does not issue that cycle and is not accepted; flush overrides issue and accept.
  - Scoreboard bits of already-issued instructions persist and clear only via writeback.
- oStallCnt increments by 1 each cycle that state==HELD && !(issue). It saturates at all-ones and is cleared only by reset.
- x0 is never set in the scoreboard. sb[0] reads 0 always.

Test Plan:
- Back-to-back independent ALU ops: rd=1,2,3, no sources, iExReady=1 → issue in consecutive cycles; oScoreboard=0x0000000E after 3 issues; oStallCnt=0.
- RAW stall: issue rd=5; next inst rs1=5. Hold iWbValid=0 for 4 cycles, then pulse iWbValid with iWbAddr=5 → oIssueValid=0 for 5 cycles and issues the cycle after sb[5] clears; oStallCnt=5.
- WAW plus same-cycle set/clear: issue rd=7. Next rd=7 stalls until writeback. Then issue rd=7 in the same cycle as iWbValid with iWbAddr=7 → sb[7] ends at 1.
- Branch: issue branch → oBrPending=1, oDecReady=0 for 3 cycles. iBrResolved pulse → next cycle state EMPTY, oDecReady=1.
- Flush while stalled: held inst rs2=9 with sb[9]=1, assert iFlushPipe → no issue; next cycle EMPTY, oDecReady=1; sb[9] remains 1.
- Reset mid-stall: sb=0x00000220 and HELD, drive iRst=0 one cycle → oScoreboard=0, oIssueValid=0, oStallCnt=0; the first accept after release issues normally.

Source files
------------

// File: rtl/issue_ctrl.sv
// Issue controller: holds one decoded instruction, blocks it on scoreboard hazards
// or an unresolved branch, and hands it to execute over a valid/ready handshake.
module issue_ctrl #(
    parameter int cRegNum    = 32,
    parameter int cAddrW     = 5,
    parameter int cStallCntW = 16
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iDecValid,
    output logic                  oDecReady,
    input  logic [cAddrW-1:0]     iRs1Addr,
    input  logic [cAddrW-1:0]     iRs2Addr,
    input  logic [cAddrW-1:0]     iRdAddr,
    input  logic                  iUsesRs1,
    input  logic                  iUsesRs2,
    input  logic                  iWritesRd,
    input  logic                  iIsBranch,
    input  logic                  iFlushPipe,
    input  logic                  iBrResolved,
    input  logic                  iWbValid,
    input  logic [cAddrW-1:0]     iWbAddr,
    input  logic                  iExReady,
    output logic                  oIssueValid,
    output logic [cAddrW-1:0]     oIssueRs1Addr,
    output logic [cAddrW-1:0]     oIssueRs2Addr,
    output logic [cAddrW-1:0]     oIssueRdAddr,
    output logic [cRegNum-1:0]    oScoreboard,
    output logic                  oBrPending,
    output logic [cStallCntW-1:0] oStallCnt
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_HELD    = 2'd1,
        ST_BR_WAIT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [cAddrW-1:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic                    uses_rs1_q, uses_rs1_d, uses_rs2_q, uses_rs2_d;
    logic                    writes_rd_q, writes_rd_d, is_br_q, is_br_d;
    logic [cRegNum-1:0]      sb_q, sb_d;
    logic [cStallCntW-1:0]   cnt_q, cnt_d;

    logic hazard, issue_valid, issue, dec_ready, accept;

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state_q     <= ST_EMPTY;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            uses_rs1_q  <= 1'b0;
            uses_rs2_q  <= 1'b0;
            writes_rd_q <= 1'b0;
            is_br_q     <= 1'b0;
            sb_q        <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            uses_rs1_q  <= uses_rs1_d;
            uses_rs2_q  <= uses_rs2_d;
            writes_rd_q <= writes_rd_d;
            is_br_q     <= is_br_d;
            sb_q        <= sb_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        // Hazard looks only at the registered scoreboard: no writeback bypass.
        hazard = (uses_rs1_q  && (rs1_q != '0) && sb_q[rs1_q]) ||
                 (uses_rs2_q  && (rs2_q != '0) && sb_q[rs2_q]) ||
                 (writes_rd_q && (rd_q  != '0) && sb_q[rd_q]);
        // Flush overrides both issue and accept for the cycle it is asserted.
        issue_valid = iRst && (state_q == ST_HELD) && !hazard && !iFlushPipe;
        issue       = issue_valid && iExReady;
        dec_ready   = iRst && !iFlushPipe &&
                      ((state_q == ST_EMPTY) || ((state_q == ST_HELD) && issue && !is_br_q));
        accept      = iDecValid && dec_ready;

        state_d     = state_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        uses_rs1_d  = uses_rs1_q;
        uses_rs2_d  = uses_rs2_q;
        writes_rd_d = writes_rd_q;
        is_br_d     = is_br_q;
        sb_d        = sb_q;
        cnt_d       = cnt_q;

        if (accept) begin
            rs1_d       = iRs1Addr;
            rs2_d       = iRs2Addr;
            rd_d        = iRdAddr;
            uses_rs1_d  = iUsesRs1;
            uses_rs2_d  = iUsesRs2;
            writes_rd_d = iWritesRd;
            is_br_d     = iIsBranch;
        end

        case (state_q)
            ST_EMPTY: begin
                if (accept) state_d = ST_HELD;
            end
            ST_HELD: begin
                if (iFlushPipe)   state_d = ST_EMPTY;
                else if (issue)   state_d = is_br_q ? ST_BR_WAIT : (accept ? ST_HELD : ST_EMPTY);
            end
            ST_BR_WAIT: begin
                if (iBrResolved) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase

        // Clear first so a same-cycle set on the same register wins.
        if (iWbValid && (iWbAddr != '0)) sb_d[iWbAddr] = 1'b0;
        if (issue && writes_rd_q && (rd_q != '0)) sb_d[rd_q] = 1'b1;
        sb_d[0] = 1'b0;

        if ((state_q == ST_HELD) && !issue && (cnt_q != '1))
            cnt_d = cnt_q + cStallCntW'(1);
    end

    assign oDecReady     = dec_ready;
    assign oIssueValid   = issue_valid;
    assign oIssueRs1Addr = rs1_q;
    assign oIssueRs2Addr = rs2_q;
    assign oIssueRdAddr  = rd_q;
    assign oScoreboard   = sb_q;
    assign oBrPending    = (state_q == ST_BR_WAIT);
    assign oStallCnt     = cnt_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed vector table, hand sequences for multi-cycle
// corners, and random traffic checked against a behavioural reference model.
module tb_issue_ctrl;

    logic        iClk = 1'b0;
    logic        iRst, iDecValid, oDecReady;
    logic [4:0]  iRs1Addr, iRs2Addr, iRdAddr, iWbAddr;
    logic        iUsesRs1, iUsesRs2, iWritesRd, iIsBranch;
    logic        iFlushPipe, iBrResolved, iWbValid, iExReady;
    logic        oIssueValid, oBrPending;
    logic [4:0]  oIssueRs1Addr, oIssueRs2Addr, oIssueRdAddr;
    logic [31:0] oScoreboard;
    logic [15:0] oStallCnt;

    always #5 iClk = ~iClk;

    issue_ctrl #(.cRegNum(32), .cAddrW(5), .cStallCntW(16)) dut (
        .iClk(iClk), .iRst(iRst), .iDecValid(iDecValid), .oDecReady(oDecReady),
        .iRs1Addr(iRs1Addr), .iRs2Addr(iRs2Addr), .iRdAddr(iRdAddr),
        .iUsesRs1(iUsesRs1), .iUsesRs2(iUsesRs2), .iWritesRd(iWritesRd),
        .iIsBranch(iIsBranch), .iFlushPipe(iFlushPipe), .iBrResolved(iBrResolved),
        .iWbValid(iWbValid), .iWbAddr(iWbAddr), .iExReady(iExReady),
        .oIssueValid(oIssueValid), .oIssueRs1Addr(oIssueRs1Addr),
        .oIssueRs2Addr(oIssueRs2Addr), .oIssueRdAddr(oIssueRdAddr),
        .oScoreboard(oScoreboard), .oBrPending(oBrPending), .oStallCnt(oStallCnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a "holding" flag, a "waiting on branch" flag and a pending-write bitmap.
    logic [31:0] m_sb;
    bit          m_hold, m_bwait;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    bit          m_u1, m_u2, m_wr, m_br;
    int          m_cnt;

    function automatic bit m_busy(input logic [4:0] a);
        return (a != 0) && m_sb[a];
    endfunction

    task automatic model_check_and_step();
        bit haz, iv, dr, iss, acc;
        haz = (m_u1 && m_busy(m_rs1)) || (m_u2 && m_busy(m_rs2)) || (m_wr && m_busy(m_rd));
        iv  = iRst && m_hold && !haz && !iFlushPipe;
        dr  = iRst && !iFlushPipe && ((!m_hold && !m_bwait) || (iv && iExReady && !m_br));
        chk("m_issue_valid", {31'b0, oIssueValid}, {31'b0, iv});
        chk("m_dec_ready",   {31'b0, oDecReady},   {31'b0, dr});
        chk("m_scoreboard",  oScoreboard, m_sb);
        chk("m_br_pending",  {31'b0, oBrPending},  {31'b0, m_bwait});
        chk("m_stall_cnt",   {16'b0, oStallCnt},   m_cnt);
        chk("m_rs1", {27'b0, oIssueRs1Addr}, {27'b0, m_rs1});
        chk("m_rs2", {27'b0, oIssueRs2Addr}, {27'b0, m_rs2});
        chk("m_rd",  {27'b0, oIssueRdAddr},  {27'b0, m_rd});
        if (!iRst) begin
            m_hold = 0; m_bwait = 0; m_sb = '0; m_cnt = 0;
            m_rs1 = '0; m_rs2 = '0; m_rd = '0;
            m_u1 = 0; m_u2 = 0; m_wr = 0; m_br = 0;
        end else begin
            iss = iv && iExReady;
            acc = iDecValid && dr;
            if (m_hold && !iss && m_cnt < 65535) m_cnt++;
            if (iWbValid && iWbAddr != 0) m_sb[iWbAddr] = 1'b0;
            if (iss && m_wr && m_rd != 0) m_sb[m_rd] = 1'b1;
            if (m_bwait) begin
                if (iBrResolved) m_bwait = 0;
            end else if (m_hold) begin
                if (iFlushPipe) m_hold = 0;
                else if (iss) begin
                    if (m_br) begin m_bwait = 1; m_hold = 0; end
                    else m_hold = acc;
                end
            end else begin
                m_hold = acc;
            end
            if (acc) begin
                m_rs1 = iRs1Addr; m_rs2 = iRs2Addr; m_rd = iRdAddr;
                m_u1 = iUsesRs1; m_u2 = iUsesRs2; m_wr = iWritesRd; m_br = iIsBranch;
            end
        end
    endtask

    task automatic cycle();
        #1;
        model_check_and_step();
        @(posedge iClk);
        @(negedge iClk);
    endtask

    task automatic idle();
        iRst = 1'b1; iDecValid = 1'b0; iRs1Addr = '0; iRs2Addr = '0; iRdAddr = '0;
        iUsesRs1 = 1'b0; iUsesRs2 = 1'b0; iWritesRd = 1'b0; iIsBranch = 1'b0;
        iFlushPipe = 1'b0; iBrResolved = 1'b0; iWbValid = 1'b0; iWbAddr = '0; iExReady = 1'b1;
    endtask

    task automatic inst(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic u1, input logic u2, input logic wr, input logic br);
        iDecValid = 1'b1; iRs1Addr = rs1; iRs2Addr = rs2; iRdAddr = rd;
        iUsesRs1 = u1; iUsesRs2 = u2; iWritesRd = wr; iIsBranch = br;
    endtask

    task automatic do_reset();
        idle();
        iRst = 1'b0;
        cycle();
        cycle();
        iRst = 1'b1;
    endtask

    typedef struct {
        logic        dv;
        logic [4:0]  rs1, rd;
        logic        u1, wr, wbv;
        logic [4:0]  wba;
        logic        iv, dr;
        logic [31:0] sb;
        int          cnt;
    } vec_t;

    function automatic vec_t mk(input logic dv, input logic [4:0] rs1, input logic [4:0] rd,
                                input logic u1, input logic wr, input logic wbv, input logic [4:0] wba,
                                input logic iv, input logic dr, input logic [31:0] sb, input int cnt);
        vec_t v;
        v.dv = dv; v.rs1 = rs1; v.rd = rd; v.u1 = u1; v.wr = wr; v.wbv = wbv; v.wba = wba;
        v.iv = iv; v.dr = dr; v.sb = sb; v.cnt = cnt;
        return v;
    endfunction

    vec_t vt[13];

    initial begin
        // Back-to-back rd=1,2,3 then a RAW stall on x5 cleared by writeback.
        vt[0]  = mk(1, 0, 1, 0, 1, 0, 0, 0, 1, 32'h0,  0);
        vt[1]  = mk(1, 0, 2, 0, 1, 0, 0, 1, 1, 32'h0,  0);
        vt[2]  = mk(1, 0, 3, 0, 1, 0, 0, 1, 1, 32'h2,  0);
        vt[3]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h6,  0);
        vt[4]  = mk(1, 0, 5, 0, 1, 0, 0, 0, 1, 32'hE,  0);
        vt[5]  = mk(1, 5, 0, 1, 0, 0, 0, 1, 1, 32'hE,  0);
        vt[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2E, 0);
        vt[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2E, 1);
        vt[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2E, 2);
        vt[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2E, 3);
        vt[10] = mk(0, 0, 0, 0, 0, 1, 5, 0, 0, 32'h2E, 4);
        vt[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hE,  5);
        vt[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hE,  5);

        idle();
        @(negedge iClk);
        do_reset();
        #1;
        chk("rst_sb", oScoreboard, 32'h0);
        chk("rst_dec_ready", {31'b0, oDecReady}, 32'h1);

        for (int i = 0; i < 13; i++) begin
            idle();
            iDecValid = vt[i].dv; iRs1Addr = vt[i].rs1; iRdAddr = vt[i].rd;
            iUsesRs1 = vt[i].u1; iWritesRd = vt[i].wr;
            iWbValid = vt[i].wbv; iWbAddr = vt[i].wba;
            #1;
            chk($sformatf("vec%0d_iv", i), {31'b0, oIssueValid}, {31'b0, vt[i].iv});
            chk($sformatf("vec%0d_dr", i), {31'b0, oDecReady}, {31'b0, vt[i].dr});
            chk($sformatf("vec%0d_sb", i), oScoreboard, vt[i].sb);
            chk($sformatf("vec%0d_cnt", i), {16'b0, oStallCnt}, vt[i].cnt);
            cycle();
        end

        // WAW stall on x7, then issue rd=7 alongside a writeback to x7.
        idle(); inst(0, 0, 7, 0, 0, 1, 0); cycle();
        idle(); inst(0, 0, 7, 0, 0, 1, 0); #1;
        chk("waw_first_issue", {31'b0, oIssueValid}, 32'h1);
        cycle();
        idle(); #1;
        chk("waw_stall", {31'b0, oIssueValid}, 32'h0);
        cycle();
        iWbValid = 1'b1; iWbAddr = 5'd7; cycle();
        #1;
        chk("waw_issue_with_wb", {31'b0, oIssueValid}, 32'h1);
        cycle();
        idle(); #1;
        chk("waw_set_wins", {31'b0, oScoreboard[7]}, 32'h1);
        iWbValid = 1'b1; iWbAddr = 5'd7; cycle();
        idle();

        // Branch: issue, hold decoder off for 3 cycles, resolve.
        inst(0, 0, 0, 0, 0, 0, 1); cycle();
        inst(0, 0, 0, 0, 0, 0, 0); #1;
        chk("br_issue_valid", {31'b0, oIssueValid}, 32'h1);
        chk("br_issue_no_accept", {31'b0, oDecReady}, 32'h0);
        cycle();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("br_pending", {31'b0, oBrPending}, 32'h1);
            chk("br_dec_ready", {31'b0, oDecReady}, 32'h0);
            cycle();
        end
        idle(); iBrResolved = 1'b1; cycle();
        idle(); #1;
        chk("br_resolved_ready", {31'b0, oDecReady}, 32'h1);
        chk("br_resolved_pending", {31'b0, oBrPending}, 32'h0);
        cycle();

        // Flush while stalled on x9.
        inst(0, 0, 9, 0, 0, 1, 0); cycle();
        inst(0, 9, 0, 0, 1, 0, 0); cycle();
        idle(); cycle();
        iFlushPipe = 1'b1; #1;
        chk("flush_no_issue", {31'b0, oIssueValid}, 32'h0);
        cycle();
        idle(); #1;
        chk("flush_ready", {31'b0, oDecReady}, 32'h1);
        chk("flush_sb9_kept", {31'b0, oScoreboard[9]}, 32'h1);
        cycle();
        iWbValid = 1'b1; iWbAddr = 5'd9; cycle();
        idle();

        // Reset mid-stall with x5 and x9 pending.
        do_reset();
        inst(0, 0, 5, 0, 0, 1, 0); cycle();
        inst(0, 0, 9, 0, 0, 1, 0); cycle();
        inst(5, 0, 0, 1, 0, 0, 0); cycle();
        idle(); #1;
        chk("mid_sb", oScoreboard, 32'h220);
        chk("mid_stalled", {31'b0, oIssueValid}, 32'h0);
        cycle();
        iRst = 1'b0; cycle();
        iRst = 1'b1; #1;
        chk("post_rst_sb", oScoreboard, 32'h0);
        chk("post_rst_iv", {31'b0, oIssueValid}, 32'h0);
        chk("post_rst_cnt", {16'b0, oStallCnt}, 32'h0);
        chk("post_rst_ready", {31'b0, oDecReady}, 32'h1);
        inst(0, 0, 4, 0, 0, 1, 0); cycle();
        idle(); #1;
        chk("post_rst_issue", {31'b0, oIssueValid}, 32'h1);
        cycle();

        // Random traffic on a narrow register range to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            iRst        = ($urandom_range(0, 199) != 0);
            iDecValid   = ($urandom_range(0, 3) != 0);
            iRs1Addr    = 5'($urandom_range(0, 7));
            iRs2Addr    = 5'($urandom_range(0, 7));
            iRdAddr     = 5'($urandom_range(0, 7));
            iUsesRs1    = 1'($urandom_range(0, 1));
            iUsesRs2    = 1'($urandom_range(0, 1));
            iWritesRd   = 1'($urandom_range(0, 1));
            iIsBranch   = ($urandom_range(0, 7) == 0);
            iFlushPipe  = ($urandom_range(0, 15) == 0);
            iBrResolved = ($urandom_range(0, 3) == 0);
            iWbValid    = 1'($urandom_range(0, 1));
            iWbAddr     = 5'($urandom_range(0, 7));
            iExReady    = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Stall counter saturation.
        do_reset();
        inst(0, 0, 6, 0, 0, 1, 0); cycle();
        inst(6, 0, 0, 1, 0, 0, 0); cycle();
        idle();
        for (int s = 0; s < 65540; s++) cycle();
        #1;
        chk("stall_cnt_saturated", {16'b0, oStallCnt}, 32'h0000FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
